// File: rtl/jtframe_dwnld_pack.sv
// Packs ioctl download bytes into byte-masked 16-bit SDRAM writes (4 banks) or PROM strobes.
// Optional macro JTFRAME_DWNLD_HEADER_EN strips the first HEADER bytes into the `header` port.
module jtframe_dwnld_pack #(
  parameter logic [24:0] BA1_START  = 25'h10_0000,
  parameter logic [24:0] BA2_START  = 25'h20_0000,
  parameter logic [24:0] BA3_START  = 25'h30_0000,
  parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
  parameter logic        SWAB       = 1'b0,
  parameter int          FIFO_AW    = 2,
  parameter int          HEADER     = 16
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic [9:0]  prom_addr,
  output logic [7:0]  prom_data,
  output logic        dwnld_busy,
`ifdef JTFRAME_DWNLD_HEADER_EN
  output logic [8*HEADER-1:0] header,
`endif
  output logic        ovf
);

  localparam int DEPTH = 2**FIFO_AW;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } entry_t;

  state_t           state;
  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full, push_req, push, pop;
  logic             accept, dl_q;
  logic [24:0]      eff_addr;
  logic             is_prom;
  logic [1:0]       bank;
  logic [22:0]      start_lo, offset_lo;
  logic             lane;

`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam int HDR_BYTES = HEADER;
  localparam int HCW       = $clog2(HEADER + 1);

  logic [HCW-1:0] hdr_cnt;
  logic           in_header;

  assign in_header = hdr_cnt < HCW'(HEADER);
  assign accept    = ioctl_wr & downloading & ~in_header;

  // Counter sits at zero while idle, so every download restarts its header capture
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt <= '0;
      header  <= '0;
    end else if (!downloading) begin
      hdr_cnt <= '0;
    end else if (ioctl_wr && in_header) begin
      header[8*hdr_cnt +: 8] <= ioctl_data;
      hdr_cnt                <= hdr_cnt + 1'b1;
    end
  end
`else
  localparam int HDR_BYTES = 0 * HEADER;

  assign accept = ioctl_wr & downloading;
`endif

  assign eff_addr = ioctl_addr - 25'(HDR_BYTES);

  always_comb begin
    is_prom  = 1'b0;
    bank     = 2'd0;
    start_lo = 23'd0;
    if (eff_addr >= PROM_START) begin
      is_prom = 1'b1;
    end else if (eff_addr >= BA3_START) begin
      bank     = 2'd3;
      start_lo = BA3_START[22:0];
    end else if (eff_addr >= BA2_START) begin
      bank     = 2'd2;
      start_lo = BA2_START[22:0];
    end else if (eff_addr >= BA1_START) begin
      bank     = 2'd1;
      start_lo = BA1_START[22:0];
    end
  end

  // Only the low 23 offset bits survive, so the subtraction is done at that width
  assign offset_lo = eff_addr[22:0] - start_lo;
  assign lane      = offset_lo[0] ^ SWAB;

  assign new_entry.ba   = bank;
  assign new_entry.addr = offset_lo[22:1];
  assign new_entry.mask = lane ? 2'b01 : 2'b10;
  assign new_entry.data = ioctl_data;

  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop      = state == LOAD;
  assign push_req = accept & ~is_prom;
  assign push     = push_req & (~full | pop);
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A write stays presented until acknowledged, then one idle cycle before the next load
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      prog_ba   <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          prog_ba   <= head.ba;
          prog_addr <= head.addr;
          prog_mask <= head.mask;
          prog_data <= {head.data, head.data};
          prog_we   <= 1'b1;
          state     <= WAIT;
        end
        WAIT: if (prog_rdy) begin
          prog_we <= 1'b0;
          state   <= GAP;
        end
        GAP: state <= empty ? IDLE : LOAD;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prom_we   <= 1'b0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= accept & is_prom;
      if (accept && is_prom) begin
        prom_addr <= eff_addr[9:0] - PROM_START[9:0];
        prom_data <= ioctl_data;
      end
    end
  end

  // A dropped byte in the same cycle as a new download start still flags the overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q       <= 1'b0;
      ovf        <= 1'b0;
      dwnld_busy <= 1'b0;
    end else begin
      dl_q       <= downloading;
      dwnld_busy <= downloading | ~empty | (state != IDLE);
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (downloading && !dl_q) ovf <= 1'b0;
    end
  end

endmodule
